// File: rtl/pipe_mux_sel.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mux_sel
//  Purpose  : Registered N-input, W-bit selector with a valid/ready handshake,
//             a single output stage and a skid buffer. It steers register-file
//             or ALU results into the next pipeline stage.
//             An out-of-range select does not pick up new data. The beat
//             carries the last successfully selected value, has err set, and
//             bumps a saturating error counter.
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             in_data        - NUM_IN packed inputs, input k at [k*WIDTH +: WIDTH]
//             in_sel         - select index, qualified by in_valid
//             in_valid       - upstream beat valid
//             in_ready       - registered accept indication (= no skid held)
//             out_data       - selected data of the presented beat
//             out_err        - presented beat came from an out-of-range select
//             out_valid      - output beat valid
//             out_ready      - downstream accepts the presented beat
//             err_cnt        - saturating count of accepted out-of-range beats
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_mux_sel #(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 3,
    parameter int SEL_W     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    localparam int                   c_SEL_SPAN = 2 ** SEL_W;
    localparam logic [SEL_W:0]       c_NUM_IN   = (SEL_W + 1)'(NUM_IN);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX  = '1;

    // Inputs unpacked into a table that covers the full select range. Slots
    // past NUM_IN are tied to zero; they are never used as data because the
    // range check below diverts such selects to the held value.
    logic [WIDTH-1:0] w_inputs [c_SEL_SPAN];

    genvar k;
    generate
        for (k = 0; k < c_SEL_SPAN; k = k + 1) begin : g_in
            if (k < NUM_IN) begin : g_real
                assign w_inputs[k] = in_data[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_inputs[k] = '0;
            end
        end
    endgenerate

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_err;
    logic                 r_skid_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic                 r_skid_err;
    logic [WIDTH-1:0]     r_last_data;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_sel_ok;
    logic [WIDTH-1:0]     w_sel_data;
    logic [WIDTH-1:0]     w_beat_data;
    logic                 w_beat_err;
    logic                 w_accept;
    logic                 w_out_free;

    // The skid register is the only place a second beat can wait. While it
    // is full the block refuses input. in_ready therefore depends only on a
    // flop and never on out_ready.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;

    assign w_sel_ok    = ({1'b0, in_sel} < c_NUM_IN);
    assign w_sel_data  = w_inputs[in_sel];
    assign w_beat_data = w_sel_ok ? w_sel_data : r_last_data;
    assign w_beat_err  = ~w_sel_ok;

    // The output stage may take a new beat when it is empty or being released.
    assign w_out_free  = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_last_data  <= '0;
            r_err_cnt    <= '0;
        end else begin
            // Resolve "last value" and error accounting at accept time. This
            // makes acceptance order, not release order, define the history.
            if (w_accept && w_sel_ok) begin
                r_last_data <= w_sel_data;
            end
            if (w_accept && !w_sel_ok && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end

            if (w_out_free) begin
                if (r_skid_valid) begin
                    // An older beat waits in skid, so it goes first. No new
                    // beat can be accepted this cycle because in_ready is low.
                    r_out_data   <= r_skid_data;
                    r_out_err    <= r_skid_err;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_data  <= w_beat_data;
                    r_out_err   <= w_beat_err;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // The output stage is stalled and occupied, so park the beat.
                r_skid_data  <= w_beat_data;
                r_skid_err   <= w_beat_err;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_mux_sel
//  Purpose  : Self-checking bench for pipe_mux_sel. It drives two instances:
//             the default configuration (16-bit, 3 inputs, 8-bit counter)
//             and a wide-select one (8-bit, 5 inputs, SEL_W=3, 2-bit counter).
//             A beat-level model pushes expected beats on accept. A monitor
//             pops and compares them when the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mux_sel;

    logic clk;
    logic rst;

    // ---------------- instance A: WIDTH=16 NUM_IN=3 SEL_W=2 ERR_CNT_W=8
    logic [47:0] a_data;
    logic [1:0]  a_sel;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [15:0] a_out_data;
    logic [7:0]  a_err_cnt;

    // ---------------- instance B: WIDTH=8 NUM_IN=5 SEL_W=3 ERR_CNT_W=2
    logic [39:0] b_data;
    logic [2:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [7:0]  b_out_data;
    logic [1:0]  b_err_cnt;

    pipe_mux_sel #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .ERR_CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_cnt(a_err_cnt)
    );

    pipe_mux_sel #(.WIDTH(8), .NUM_IN(5), .SEL_W(3), .ERR_CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_cnt(b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: beats in flight, {err, data}
    logic [16:0] qa [$];
    logic [15:0] ma_last = '0;
    int          ma_cnt  = 0;
    logic [8:0]  qb [$];
    logic [7:0]  mb_last = '0;
    int          mb_cnt  = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            qa.delete(); ma_last = '0; ma_cnt = 0;
            qb.delete(); mb_last = '0; mb_cnt = 0;
        end else begin
            if (a_in_valid && a_in_ready) begin
                if (int'(a_sel) < 3) begin
                    ma_last = a_data[int'(a_sel)*16 +: 16];
                    qa.push_back({1'b0, ma_last});
                end else begin
                    qa.push_back({1'b1, ma_last});
                    if (ma_cnt < 255) ma_cnt++;
                end
            end
            if (b_in_valid && b_in_ready) begin
                if (int'(b_sel) < 5) begin
                    mb_last = b_data[int'(b_sel)*8 +: 8];
                    qb.push_back({1'b0, mb_last});
                end else begin
                    qb.push_back({1'b1, mb_last});
                    if (mb_cnt < 3) mb_cnt++;
                end
            end
        end
    end

    // ---------------- monitors: mid-cycle sampling
    initial forever begin
        @(negedge clk);
        chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
        chk("a_in_ready",  32'(a_in_ready),  32'(qa.size() < 2));
        chk("a_err_cnt",   32'(a_err_cnt),   32'(ma_cnt));
        if (qa.size() != 0 && a_out_valid) begin
            chk("a_out_data", 32'(a_out_data), 32'(qa[0][15:0]));
            chk("a_out_err",  32'(a_out_err),  32'(qa[0][16]));
            if (a_out_ready) void'(qa.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
        chk("b_in_ready",  32'(b_in_ready),  32'(qb.size() < 2));
        chk("b_err_cnt",   32'(b_err_cnt),   32'(mb_cnt));
        if (qb.size() != 0 && b_out_valid) begin
            chk("b_out_data", 32'(b_out_data), 32'(qb[0][7:0]));
            chk("b_out_err",  32'(b_out_err),  32'(qb[0][8]));
            if (b_out_ready) void'(qb.pop_front());
        end
    end

    // ---------------- drivers: inputs change 1 time unit after the edge
    task automatic step_a(input logic v, input logic [1:0] s, input logic r, input logic [47:0] d);
        a_in_valid = v; a_sel = s; a_out_ready = r; a_data = d;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic v, input logic [2:0] s, input logic r, input logic [39:0] d);
        b_in_valid = v; b_sel = s; b_out_ready = r; b_data = d;
        @(posedge clk); #1;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [39:0] rnd40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    localparam logic [47:0] c_A_VEC = {16'h3333, 16'h2222, 16'h1111};

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_sel = 0; a_out_ready = 1; a_data = '0;
        b_in_valid = 0; b_sel = 0; b_out_ready = 1; b_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Select sweep, then an out-of-range select repeats 0x2222.
        step_a(1, 2'd0, 1, c_A_VEC);
        step_a(1, 2'd1, 1, c_A_VEC);
        step_a(1, 2'd2, 1, c_A_VEC);
        step_a(1, 2'd1, 1, c_A_VEC);
        step_a(1, 2'd3, 1, c_A_VEC);
        chk("a_oor_cnt",  32'(a_err_cnt),  32'd1);
        chk("a_oor_data", 32'(a_out_data), 32'h2222);
        chk("a_oor_err",  32'(a_out_err),  32'd1);
        step_a(0, 2'd0, 1, '0);

        // Backpressure: A goes out, then B/C/D arrive while the output stalls.
        step_a(1, 2'd0, 1, rnd48());
        step_a(1, 2'd1, 0, rnd48());
        chk("a_skid_ready", 32'(a_in_ready), 32'd0);
        step_a(1, 2'd2, 0, rnd48());
        step_a(1, 2'd2, 0, rnd48());
        for (int i = 0; i < 4; i++) step_a(1, 2'($urandom_range(0, 2)), 1, rnd48());
        step_a(0, 2'd0, 1, '0);
        step_a(0, 2'd0, 1, '0);

        // Mid-operation reset with skid full and output holding.
        step_a(1, 2'd3, 0, rnd48());
        step_a(1, 2'd0, 0, rnd48());
        step_a(1, 2'd1, 0, rnd48());
        rst = 1'b1;
        step_a(1, 2'd2, 0, rnd48());
        rst = 1'b0;
        chk("a_rst_ready", 32'(a_in_ready), 32'd1);
        chk("a_rst_valid", 32'(a_out_valid), 32'd0);
        step_a(1, 2'd3, 1, rnd48());
        chk("a_rst_last", 32'(a_out_data), 32'h0000);
        chk("a_rst_err",  32'(a_out_err),  32'd1);

        // Randomised traffic with occasional resets; in_data/in_sel toggle
        // even when invalid.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            step_a(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 2) != 0), rnd48());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step_a(0, 2'($urandom), 1, rnd48());
        chk("a_drain", 32'(qa.size()), 32'd0);

        // Instance B: wide select and counter saturation.
        rst = 1'b1;
        step_b(0, 3'd0, 1, '0);
        rst = 1'b0;
        step_b(1, 3'd4, 1, 40'hA5_44_33_22_11);
        chk("b_sel4", 32'(b_out_data), 32'hA5);
        for (int s = 5; s < 10; s++) step_b(1, 3'(s > 7 ? s - 3 : s), 1, rnd40());
        chk("b_sat_cnt",  32'(b_err_cnt),  32'd3);
        chk("b_sat_data", 32'(b_out_data), 32'hA5);
        for (int s = 0; s < 8; s++) step_b(1, 3'(s), ($urandom_range(0, 1) != 0), rnd40());
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            step_b(($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 2) != 0), rnd40());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step_b(0, 3'($urandom), 1, rnd40());
        chk("b_drain", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_mux_sel.md
Name: pipe_mux_sel

Overview:
- Parametrised, registered N-input W-bit selector for datapath operand/result steering in the 16-bit CPU.
- Successor to the unclocked 3:1 bit mux: arbitrary width and input count, valid/ready handshake, one pipeline stage with skid buffer.
- Defined handling of out-of-range selects: hold last value, flag the beat, count errors.
- Sits between register-file/ALU outputs and the next pipeline stage.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select index, qualified by in_valid.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat; registered.
- out_data  output  WIDTH  selected data.
- out_err  output  1  beat was produced from an out-of-range select.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- err_cnt  output  ERR_CNT_W  saturating count of accepted out-of-range beats.

Behaviour:
- Reset (rst=1 at clock edge), all cleared to 0: out_valid, out_data, out_err, err_cnt, skid_valid, last_data. in_ready=1 in the cycle after reset. Reset overrides any in-flight beat; held beats are dropped.
- Accept: in_valid & in_ready at a clock edge. Release: out_valid & out_ready at a clock edge.
- Select resolution at accept time:
  - in_sel < NUM_IN: data = input[in_sel], err=0, and last_data <= data.
  - in_sel >= NUM_IN: data = last_data (unchanged), err=1, err_cnt increments, saturating at all-ones.
- Latency: an accepted beat appears on out_data/out_valid the cycle after acceptance. Throughput is 1 beat/cycle while out_ready=1.
- in_ready = ~skid_valid; it is a flop output with no combinational path from out_ready.
- Output stage load: when the stage is empty (out_valid=0) or releasing, it loads from skid if skid_valid, else from an accepting input beat, else out_valid <= 0.
- Skid capture: when an accept occurs, out_valid=1, out_ready=0, and the output stage is occupied, the beat (data, err) goes to the skid register and skid_valid <= 1. Next cycle in_ready=0.
- Skid drain: on release with skid_valid=1, skid moves to the output stage and skid_valid <= 0. in_ready returns to 1 the following cycle.
- Ordering: strict FIFO order across skid/output; no beat is lost or duplicated. Maximum occupancy is 2.
- Stability: while out_valid=1 and out_ready=0, out_data and out_err do not change.
- Resolution timing: err and last_data are resolved when the beat is accepted, not when it is released, so beat order defines "last".
- Errored beats flow through the handshake like normal beats.
- in_data and in_sel are ignored when in_valid=0.

Test Plan:
- Reset then sel sweep, out_ready=1, WIDTH=16, NUM_IN=3, inputs 0x1111/0x2222/0x3333, sel 0,1,2 on consecutive cycles.
  -> out_data 0x1111, 0x2222, 0x3333 one cycle after each accept; out_valid continuous; out_err=0.
- Out-of-range select: sel=1 (0x2222) then sel=3.
  -> second beat out_data=0x2222, out_err=1, err_cnt=1.
  -> sel=3 immediately after reset gives out_data=0x0000, out_err=1.
- Backpressure: stream 4 beats A,B,C,D; out_ready=0 for 3 cycles after A appears.
  -> B captured in skid, in_ready=0 next cycle, out_data holds A.
  -> After out_ready=1, output order is A,B,C,D with no loss or duplication.
- Error counter saturation: ERR_CNT_W=2, 5 accepted out-of-range beats.
  -> err_cnt 1,2,3,3,3.
- Mid-operation reset: skid full, output holding, rst=1 for one cycle.
  -> next cycle out_valid=0, in_ready=1, err_cnt=0.
  -> subsequent sel=3 outputs 0x0000 (last_data cleared).
- Parametrisation: NUM_IN=5, SEL_W=3, WIDTH=8.
  -> sel 4 selects in_data[39:32].
  -> sel 5..7 flagged out_err with last value held.
